jk_seq_ctrl: RTL and testbench
==============================

// Module: jk_seq_ctrl
// PURPOSE
//  Command sequencer for a WIDTH-bit register bank of JK flip-flops.
//  Accepts one command at a time over a valid/ready handshake and drives per-bit j/k each cycle:
//  - single-cycle ops: clear, set, load
//  - multi-step ops: toggle, count, shift
//  Reports completion with a one-cycle done pulse. Primary user of the JK/T cell library.
// PARAMETERS
//  WIDTH  8  register bank width in bits (>=2)
//  CNT_W  8  width of the step-count field cmd_len
// PORTS
//  clk        in   1      rising-edge clock, single clock domain
//  rst        in   1      synchronous reset, active-high
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      controller can accept a command (state IDLE, rst low)
//  cmd_op     in   3      opcode (see BEHAVIOUR)
//  cmd_data   in   WIDTH  load value / toggle mask / shift-in bit (bit 0)
//  cmd_len    in   CNT_W  step count for TOGGLE/COUNT/SHIFT; 0 is treated as 1
//  q          out  WIDTH  register bank true outputs
//  qbar       out  WIDTH  register bank complement outputs
//  busy       out  1      command in progress (EXEC or DONE)
//  done       out  1      one-cycle pulse, command completed
//  err        out  1      valid with done: opcode was illegal
// BEHAVIOUR
//  - Reset (rst=1 at an edge): q=0, qbar=all-ones, state=IDLE, busy=0, done=0, err=0.
//    cmd_ready=0 while rst is high. Reset mid-command abandons the command; no done pulse.
//  - Invariant: qbar == ~q on every cycle.
//  - Opcodes:
//    000 NOP: no bank change.
//    001 CLEAR: j=0, k=1 on all bits.
//    010 SET: j=1, k=0 on all bits.
//    011 LOAD: j=d, k=~d, giving q<=cmd_data.
//    100 TOGGLE: j=k=mask, giving q<=q^mask, repeated len times.
//    101 COUNT: T_i = &q[i-1:0] (T_0=1); up-count by 1 per step, len steps.
//        Wraps all-ones -> 0.
//    110 SHIFT: q<={q[W-2:0], cmd_data[0]} per step, len steps.
//        Per bit: j=src, k=~src.
//    111 illegal: no bank change, err=1 with done.
//  - Handshake: a command is accepted at an edge with cmd_valid && cmd_ready.
//    op, data and len are latched at that edge. cmd_valid while busy is ignored, not queued.
//  - FSM:
//    IDLE: cmd_ready=1. Go to EXEC on accept.
//    EXEC: j/k are driven from latched op/data and current q. The bank updates at each edge.
//      rem counter starts at max(len,1); NOP/CLEAR/SET/LOAD/illegal use rem=1.
//      rem decrements each edge. At the edge where rem==1, go to DONE.
//    DONE: done=1, busy=1, cmd_ready=0, j=k=0 (hold). Go to IDLE on the next edge.
//  - Latency: an n-step command accepted at edge E0 applies steps at E1..En.
//    DONE is visible after En. The next accept is possible at edge En+2.
//  - Outside EXEC, all cells see j=k=0 (hold).
//  - err is cleared on the next accept.
// STRUCTURE
//  - Package jk_seq_pkg:
//    opcode localparams OP_NOP..OP_ILL.
//    FSM state encoding S_IDLE/S_EXEC/S_DONE (2-bit).
//  - Sub-module jk_ff_cell, instantiated WIDTH times via generate:
//    JK flip-flop with synchronous active-high rst (q=0, qbar=1).
//    Truth table: 00 hold, 01 reset, 10 set, 11 toggle.
//  - Top level holds the FSM, rem counter, latched command and per-bit j/k decode.
// TESTING
//  1. rst high 2 cycles, then low
//     -> q=0x00, qbar=0xFF, cmd_ready=1, busy=0, done=0.
//  2. LOAD data=0xA5 accepted at E0
//     -> q=0xA5, qbar=0x5A after E1; done=1 in the cycle after E1; cmd_ready=1 after E2.
//  3. LOAD 0xFE, then COUNT len=3
//     -> q sequence 0xFF, 0x00, 0x01 (wrap checked); done after third step.
//  4. LOAD 0xA5, then TOGGLE mask=0x0F len=2
//     -> q=0xAA, then 0xA5. LOAD 0x81, then SHIFT data[0]=1 len=4 -> q ends 0x1F.
//  5. COUNT len=0 from 0x10
//     -> single step, q=0x11. Op 111 -> q unchanged, done=1 with err=1.
//     Next LOAD clears err.
//  6. COUNT len=200; assert rst at step 5
//     -> q=0x00, state IDLE, no done pulse.
//     cmd_valid held during busy -> no second accept.

Source files
------------

// File: rtl/jk_seq_pkg.sv
// rtl/jk_seq_pkg.sv - opcodes, FSM state encoding and opcode helpers for jk_seq_ctrl
package jk_seq_pkg;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_SET    = 3'b010;
    localparam logic [2:0] OP_LOAD   = 3'b011;
    localparam logic [2:0] OP_TOGGLE = 3'b100;
    localparam logic [2:0] OP_COUNT  = 3'b101;
    localparam logic [2:0] OP_SHIFT  = 3'b110;
    localparam logic [2:0] OP_ILL    = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Only these opcodes honour cmd_len; everything else is a single step.
    function automatic logic is_multi(input logic [2:0] op);
        return (op == OP_TOGGLE) || (op == OP_COUNT) || (op == OP_SHIFT);
    endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// rtl/jk_ff_cell.sv - JK flip-flop cell with synchronous active-high reset
module jk_ff_cell (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_j,
    input  logic i_k,
    output logic o_q,
    output logic o_qbar
);

    logic r_q;
    logic r_qbar;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q    <= 1'b0;
            r_qbar <= 1'b1;
        end else begin
            case ({i_j, i_k})
                2'b01: begin
                    r_q    <= 1'b0;
                    r_qbar <= 1'b1;
                end
                2'b10: begin
                    r_q    <= 1'b1;
                    r_qbar <= 1'b0;
                end
                2'b11: begin
                    r_q    <= ~r_q;
                    r_qbar <= ~r_qbar;
                end
                default: begin
                    r_q    <= r_q;
                    r_qbar <= r_qbar;
                end
            endcase
        end
    end

    assign o_q    = r_q;
    assign o_qbar = r_qbar;

endmodule

// File: rtl/jk_seq_ctrl.sv
// rtl/jk_seq_ctrl.sv - command sequencer driving per-bit j/k of a JK register bank
module jk_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_len,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             busy,
    output logic             done,
    output logic             err
);
    import jk_seq_pkg::*;

    state_t             r_state;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_data;
    logic [CNT_W-1:0]   r_rem;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_qbar;
    logic [WIDTH-1:0]   w_j;
    logic [WIDTH-1:0]   w_k;
    logic [WIDTH-1:0]   w_t;
    logic [WIDTH-1:0]   w_src;

    assign cmd_ready = (r_state == S_IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= OP_NOP;
            r_data  <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (cmd_valid) begin
                        r_state <= S_EXEC;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_op    <= cmd_op;
                        r_data  <= cmd_data;
                        r_rem   <= (is_multi(cmd_op) && (cmd_len != '0)) ? cmd_len : CNT_W'(1);
                    end
                end
                S_EXEC: begin
                    if (r_rem == CNT_W'(1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= (r_op == OP_ILL);
                    end else begin
                        r_rem <= r_rem - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Bits that flip on +1 are exactly those whose lower bits are all ones.
    assign w_t   = w_q ^ (w_q + WIDTH'(1));
    assign w_src = {w_q[WIDTH-2:0], r_data[0]};

    always_comb begin
        w_j = '0;
        w_k = '0;
        if (r_state == S_EXEC) begin
            case (r_op)
                OP_CLEAR: begin
                    w_j = '0;
                    w_k = '1;
                end
                OP_SET: begin
                    w_j = '1;
                    w_k = '0;
                end
                OP_LOAD: begin
                    w_j = r_data;
                    w_k = ~r_data;
                end
                OP_TOGGLE: begin
                    w_j = r_data;
                    w_k = r_data;
                end
                OP_COUNT: begin
                    w_j = w_t;
                    w_k = w_t;
                end
                OP_SHIFT: begin
                    w_j = w_src;
                    w_k = ~w_src;
                end
                default: begin
                    w_j = '0;
                    w_k = '0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        jk_ff_cell u_cell (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_j    (w_j[gi]),
            .i_k    (w_k[gi]),
            .o_q    (w_q[gi]),
            .o_qbar (w_qbar[gi])
        );
    end

    assign q    = w_q;
    assign qbar = w_qbar;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// tb/tb_jk_seq_ctrl.sv - self-checking bench for jk_seq_ctrl
module tb_jk_seq_ctrl;

    localparam int W  = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [W-1:0]  cmd_data;
    logic [CW-1:0] cmd_len;
    logic [W-1:0]  q;
    logic [W-1:0]  qbar;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    jk_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .q         (q),
        .qbar      (qbar),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) check("qbar_inv", {24'd0, qbar}, {24'd0, ~q});
    end

    function automatic int model_steps(input logic [2:0] op, input logic [CW-1:0] len);
        if (op >= 3'd4 && op <= 3'd6) return (len == 0) ? 1 : int'(len);
        return 1;
    endfunction

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] d,
                                           input logic [CW-1:0] len, input logic [W-1:0] q0);
        int n;
        int v;
        n = model_steps(op, len);
        case (op)
            3'd1: return '0;
            3'd2: return '1;
            3'd3: return d;
            3'd4: return (n % 2 == 1) ? (q0 ^ d) : q0;
            3'd5: begin
                v = (int'(q0) + n) % 256;
                return W'(v);
            end
            3'd6: begin
                if (n >= W) return d[0] ? '1 : '0;
                v = ((int'(q0) << n) & 255) | (d[0] ? ((1 << n) - 1) : 0);
                return W'(v);
            end
            default: return q0;
        endcase
    endfunction

    task automatic accept(input logic [2:0] op, input logic [W-1:0] d, input logic [CW-1:0] len,
                          input bit hold, input string tag);
        @(negedge clk);
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge clk);
        check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_len   = len;
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] d, input logic [CW-1:0] len,
                           input logic [W-1:0] exp_q, input logic exp_err, input int exp_steps,
                           input string tag);
        int  steps;
        bit  seen;
        accept(op, d, len, 1'b0, tag);
        steps = 0;
        seen  = 0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            steps++;
            @(posedge clk);
            #1;
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_steps"}, steps, exp_steps);
        check({tag, "_q"}, {24'd0, q}, {24'd0, exp_q});
        check({tag, "_qbar"}, {24'd0, qbar}, {24'd0, ~exp_q});
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    typedef struct {
        logic [2:0]    op;
        logic [W-1:0]  data;
        logic [CW-1:0] len;
        logic [W-1:0]  exp_q;
        logic          exp_err;
        int            exp_steps;
    } vec_t;

    vec_t vecs[13];
    logic [W-1:0] mq;

    initial begin
        vecs[0]  = '{3'b011, 8'hA5, 8'd0, 8'hA5, 1'b0, 1};
        vecs[1]  = '{3'b011, 8'hFE, 8'd0, 8'hFE, 1'b0, 1};
        vecs[2]  = '{3'b101, 8'h00, 8'd3, 8'h01, 1'b0, 3};
        vecs[3]  = '{3'b011, 8'hA5, 8'd0, 8'hA5, 1'b0, 1};
        vecs[4]  = '{3'b100, 8'h0F, 8'd2, 8'hA5, 1'b0, 2};
        vecs[5]  = '{3'b011, 8'h81, 8'd0, 8'h81, 1'b0, 1};
        vecs[6]  = '{3'b110, 8'h01, 8'd4, 8'h1F, 1'b0, 4};
        vecs[7]  = '{3'b011, 8'h10, 8'd0, 8'h10, 1'b0, 1};
        vecs[8]  = '{3'b101, 8'h00, 8'd0, 8'h11, 1'b0, 1};
        vecs[9]  = '{3'b111, 8'h55, 8'd9, 8'h11, 1'b1, 1};
        vecs[10] = '{3'b011, 8'h3C, 8'd0, 8'h3C, 1'b0, 1};
        vecs[11] = '{3'b010, 8'h00, 8'd7, 8'hFF, 1'b0, 1};
        vecs[12] = '{3'b001, 8'h00, 8'd7, 8'h00, 1'b0, 1};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 3'b000;
        cmd_data = '0;
        cmd_len = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_q", {24'd0, q}, 32'h00);
        check("rst_qbar", {24'd0, qbar}, 32'hFF);
        check("rst_ready_low", {31'd0, cmd_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);

        for (int i = 0; i < 13; i++)
            run_cmd(vecs[i].op, vecs[i].data, vecs[i].len, vecs[i].exp_q,
                    vecs[i].exp_err, vecs[i].exp_steps, $sformatf("vec%0d", i));

        // Step-by-step count through the wrap point
        run_cmd(3'b011, 8'hFE, 8'd0, 8'hFE, 1'b0, 1, "seq_load");
        accept(3'b101, 8'h00, 8'd3, 1'b0, "seq_cnt");
        @(posedge clk); #1;
        check("seq_cnt_s1", {24'd0, q}, 32'hFF);
        @(posedge clk); #1;
        check("seq_cnt_s2", {24'd0, q}, 32'h00);
        check("seq_cnt_s2_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        check("seq_cnt_s3", {24'd0, q}, 32'h01);
        check("seq_cnt_done", {31'd0, done}, 32'd1);

        // Toggle intermediate value
        run_cmd(3'b011, 8'hA5, 8'd0, 8'hA5, 1'b0, 1, "seq_load2");
        accept(3'b100, 8'h0F, 8'd2, 1'b0, "seq_tog");
        @(posedge clk); #1;
        check("seq_tog_s1", {24'd0, q}, 32'hAA);
        @(posedge clk); #1;
        check("seq_tog_s2", {24'd0, q}, 32'hA5);

        // cmd_valid held while busy: later data must not be taken
        run_cmd(3'b011, 8'h00, 8'd0, 8'h00, 1'b0, 1, "hold_pre");
        accept(3'b011, 8'h33, 8'd0, 1'b1, "hold");
        cmd_data = 8'hCC;
        check("hold_busy", {31'd0, busy}, 32'd1);
        check("hold_notready", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        check("hold_done", {31'd0, done}, 32'd1);
        check("hold_q", {24'd0, q}, 32'h33);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("hold_q2", {24'd0, q}, 32'h33);
        check("hold_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of a long count
        run_cmd(3'b011, 8'h00, 8'd0, 8'h00, 1'b0, 1, "abort_pre");
        accept(3'b101, 8'h00, 8'd200, 1'b0, "abort");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        check("abort_mid_q", {24'd0, q}, 32'h04);
        rst = 1'b1;
        #1;
        check("abort_ready_low", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_q", {24'd0, q}, 32'h00);
        check("abort_qbar", {24'd0, qbar}, 32'hFF);
        check("abort_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            check("abort_nodone", {31'd0, done}, 32'd0);
            @(posedge clk); #1;
        end
        check("abort_q_hold", {24'd0, q}, 32'h00);
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);

        // Randomised commands against the reference model
        mq = q;
        for (int i = 0; i < 60; i++) begin
            logic [2:0]    r_op;
            logic [W-1:0]  r_d;
            logic [CW-1:0] r_len;
            logic [W-1:0]  r_exp;
            r_op  = 3'($urandom_range(0, 7));
            r_d   = W'($urandom);
            r_len = ($urandom_range(0, 4) == 0) ? '0 : CW'($urandom_range(1, 12));
            r_exp = model(r_op, r_d, r_len, mq);
            run_cmd(r_op, r_d, r_len, r_exp, (r_op == 3'b111), model_steps(r_op, r_len),
                    $sformatf("rnd%0d", i));
            mq = r_exp;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
